// File: rtl/ntt_sequencer.sv
// ---------------------------------------------------------------------------
// ntt_sequencer
//
// Address/control sequencer for an in-place 256-point NTT / inverse NTT.
// It walks 7 layers of 128 butterflies and issues one coefficient RAM read
// per cycle. Operand addresses are delayed through a shift register and
// come back out as write-back addresses once the butterfly result is ready.
// After each layer, a drain phase lets the final write of that layer land
// before the next layer issues its first read.
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   start, is_ntt       : transform request and direction (1 = forward)
//   host_req / host_gnt : host RAM ownership handshake, granted only in IDLE
//   rd_en, rd_addr0/1   : engine read strobe and butterfly operand addresses
//   tw_addr             : twiddle ROM index for the current butterfly
//   bf_in_valid         : operands present at the butterfly input
//   bf_mode             : direction latched at start
//   wr_en, wr_addr0/1   : write-back strobe and addresses
//   layer, busy, done   : progress / status
//   dbg_state_o         : current FSM state (IDLE=0, RUN=1, DRAIN=2, DONE=3)
//
// Handshake: start is accepted only in IDLE, and only while host_req is low.
// host_gnt follows host_req in IDLE. In every other state it is 0, and a
// running transform is never preempted.
// ---------------------------------------------------------------------------
module ntt_sequencer #(
    parameter int WIDTH_ADDR_BUTTERFLY = 8,
    parameter int WIDTH_ADDR_ZETAS     = 7,
    parameter int BF_LATENCY           = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            is_ntt,
    input  logic                            host_req,
    output logic                            host_gnt,
    output logic                            rd_en,
    output logic [WIDTH_ADDR_BUTTERFLY-1:0] rd_addr0,
    output logic [WIDTH_ADDR_BUTTERFLY-1:0] rd_addr1,
    output logic [WIDTH_ADDR_ZETAS-1:0]     tw_addr,
    output logic                            bf_in_valid,
    output logic                            bf_mode,
    output logic                            wr_en,
    output logic [WIDTH_ADDR_BUTTERFLY-1:0] wr_addr0,
    output logic [WIDTH_ADDR_BUTTERFLY-1:0] wr_addr1,
    output logic [2:0]                      layer,
    output logic                            busy,
    output logic                            done,
    output logic [1:0]                      dbg_state_o
);

    // Read-to-write distance: 1 cycle of RAM read latency plus the butterfly latency.
    localparam int DEPTH = BF_LATENCY + 1;
    localparam logic [3:0] DRAIN_LAST = 4'(BF_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] layer_q, layer_d;
    logic [6:0] idx_q,   idx_d;
    logic       mode_q,  mode_d;
    logic [3:0] drain_q, drain_d;

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            layer_q <= 3'd0;
            idx_q   <= 7'd0;
            mode_q  <= 1'b0;
            drain_q <= 4'd0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            drain_q <= drain_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (start && !host_req) begin
                    state_d = S_RUN;
                    layer_d = 3'd0;
                    idx_d   = 7'd0;
                    mode_d  = is_ntt;
                end
            end
            S_RUN: begin
                // idx wraps from 127 to 0, which is the start value for the next layer.
                idx_d = idx_q + 7'd1;
                if (idx_q == 7'd127) begin
                    state_d = S_DRAIN;
                    drain_d = 4'd0;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    if (layer_q == 3'd6) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                        layer_d = layer_q + 3'd1;
                        idx_d   = 7'd0;
                    end
                end else begin
                    drain_d = drain_q + 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Status outputs
    // -----------------------------------------------------------------------
    always_comb begin
        rd_en       = (state_q == S_RUN);
        busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
        done        = (state_q == S_DONE);
        // rst_n gates the grant so that the output is 0 for the whole reset.
        host_gnt    = (state_q == S_IDLE) && host_req && rst_n;
        layer       = layer_q;
        bf_mode     = mode_q;
        dbg_state_o = state_q;
    end

    // -----------------------------------------------------------------------
    // Butterfly address generation.
    // All arithmetic is 9 bits wide, then truncated to the port widths.
    // Each group of butterflies covers 2*len consecutive coefficients.
    // -----------------------------------------------------------------------
    logic [8:0] idx9;
    logic [8:0] len;
    logic [8:0] grp;
    logic [8:0] off;
    logic [8:0] base0;
    logic [8:0] base1;
    logic [8:0] tw9;

    always_comb begin
        idx9 = {2'b00, idx_q};
        if (mode_q) begin
            // Forward: span halves every layer (128 down to 2)
            len = 9'd128 >> layer_q;
            grp = idx9 >> (3'd7 - layer_q);
            tw9 = (9'd1 << layer_q) + grp;
        end else begin
            // Inverse: span doubles every layer (2 up to 128)
            len = 9'd2 << layer_q;
            grp = idx9 >> (layer_q + 3'd1);
            tw9 = (9'd128 >> layer_q) - 9'd1 - grp;
        end
        off   = idx9 & (len - 9'd1);
        base0 = ((len << 1) * grp) + off;
        base1 = base0 + len;
    end

    always_comb begin
        rd_addr0 = '0;
        rd_addr1 = '0;
        tw_addr  = '0;
        if (rd_en) begin
            rd_addr0 = base0[WIDTH_ADDR_BUTTERFLY-1:0];
            rd_addr1 = base1[WIDTH_ADDR_BUTTERFLY-1:0];
            tw_addr  = tw9[WIDTH_ADDR_ZETAS-1:0];
        end
    end

    // The upper bits of the 9-bit intermediates are dropped by design.
    logic unused_bits;
    assign unused_bits = ^{tw9, base0, base1};

    // -----------------------------------------------------------------------
    // Read-to-write delay line.
    // Stage 0 is also the butterfly operand-valid flag.
    // -----------------------------------------------------------------------
    logic [DEPTH-1:0]                en_sr_q;
    logic [WIDTH_ADDR_BUTTERFLY-1:0] a0_sr_q [DEPTH];
    logic [WIDTH_ADDR_BUTTERFLY-1:0] a1_sr_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_sr_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                a0_sr_q[k] <= '0;
                a1_sr_q[k] <= '0;
            end
        end else begin
            en_sr_q[0] <= rd_en;
            a0_sr_q[0] <= rd_addr0;
            a1_sr_q[0] <= rd_addr1;
            for (int k = 1; k < DEPTH; k++) begin
                en_sr_q[k] <= en_sr_q[k-1];
                a0_sr_q[k] <= a0_sr_q[k-1];
                a1_sr_q[k] <= a1_sr_q[k-1];
            end
        end
    end

    always_comb begin
        bf_in_valid = en_sr_q[0];
        wr_en       = en_sr_q[DEPTH-1];
        wr_addr0    = '0;
        wr_addr1    = '0;
        if (wr_en) begin
            wr_addr0 = a0_sr_q[DEPTH-1];
            wr_addr1 = a1_sr_q[DEPTH-1];
        end
    end

endmodule

// File: tb/tb_ntt_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ntt_sequencer
//
// Directed bench for ntt_sequencer at its default parameters.
//   - Forward and inverse transforms: first read of each layer, mid-layer
//     addresses, latency, address coverage, write-back pairing/timing and
//     inter-layer hazard gap.
//   - Arbitration in IDLE and while a transform is running.
//   - Reset in the middle of a transform.
// ---------------------------------------------------------------------------
module tb_ntt_sequencer;

    localparam int WAB = 8;
    localparam int WZ  = 7;
    localparam int LAT = 4;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic           is_ntt;
    logic           host_req;
    logic           host_gnt;
    logic           rd_en;
    logic [WAB-1:0] rd_addr0;
    logic [WAB-1:0] rd_addr1;
    logic [WZ-1:0]  tw_addr;
    logic           bf_in_valid;
    logic           bf_mode;
    logic           wr_en;
    logic [WAB-1:0] wr_addr0;
    logic [WAB-1:0] wr_addr1;
    logic [2:0]     layer;
    logic           busy;
    logic           done;
    logic [1:0]     dbg_state_o;

    ntt_sequencer #(
        .WIDTH_ADDR_BUTTERFLY (WAB),
        .WIDTH_ADDR_ZETAS     (WZ),
        .BF_LATENCY           (LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_ntt      (is_ntt),
        .host_req    (host_req),
        .host_gnt    (host_gnt),
        .rd_en       (rd_en),
        .rd_addr0    (rd_addr0),
        .rd_addr1    (rd_addr1),
        .tw_addr     (tw_addr),
        .bf_in_valid (bf_in_valid),
        .bf_mode     (bf_mode),
        .wr_en       (wr_en),
        .wr_addr0    (wr_addr0),
        .wr_addr1    (wr_addr1),
        .layer       (layer),
        .busy        (busy),
        .done        (done),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Hand-computed first read of each layer (rd_addr0 is always 0).
    int fwd_a1[7] = '{128, 64, 32, 16, 8, 4, 2};
    int fwd_tw[7] = '{1, 2, 4, 8, 16, 32, 64};
    int inv_a1[7] = '{2, 4, 8, 16, 32, 64, 128};
    int inv_tw[7] = '{127, 63, 31, 15, 7, 3, 1};

    task automatic check_all_zero(input string tag);
        check_val({tag, "_host_gnt"}, 32'(host_gnt), 0);
        check_val({tag, "_rd_en"},    32'(rd_en), 0);
        check_val({tag, "_rd_addr0"}, 32'(rd_addr0), 0);
        check_val({tag, "_rd_addr1"}, 32'(rd_addr1), 0);
        check_val({tag, "_tw_addr"},  32'(tw_addr), 0);
        check_val({tag, "_bf_valid"}, 32'(bf_in_valid), 0);
        check_val({tag, "_bf_mode"},  32'(bf_mode), 0);
        check_val({tag, "_wr_en"},    32'(wr_en), 0);
        check_val({tag, "_wr_addr0"}, 32'(wr_addr0), 0);
        check_val({tag, "_wr_addr1"}, 32'(wr_addr1), 0);
        check_val({tag, "_layer"},    32'(layer), 0);
        check_val({tag, "_busy"},     32'(busy), 0);
        check_val({tag, "_done"},     32'(done), 0);
        check_val({tag, "_state"},    32'(dbg_state_o), 0);
    endtask

    // ---------------- full transform with scoreboard ----------------
    // k counts negedge samples after the edge that accepted start.
    task automatic run_transform(input logic mode, input bit arb);
        logic [32:0] exp_q[$];      // {layer, read cycle, addr0, addr1}
        logic [32:0] e;
        int cov_rd[7][256];
        int cov_wr[7][256];
        int rcnt[7];
        int first_rd[7];
        int last_rd[7];
        int last_wr[7];
        int done_k = 0;
        int n_rd = 0;
        int n_wr = 0;
        int wb_bad = 0;
        int idle_bad = 0;
        int vld_bad = 0;
        int busy_bad = 0;
        int gnt_hi = 0;
        int cov_bad = 0;
        int s;
        logic prev_rd = 1'b0;
        string pfx;

        pfx = mode ? "fwd" : "inv";
        for (int l = 0; l < 7; l++) begin
            rcnt[l] = 0; first_rd[l] = 0; last_rd[l] = 0; last_wr[l] = 0;
            for (int a = 0; a < 256; a++) begin
                cov_rd[l][a] = 0;
                cov_wr[l][a] = 0;
            end
        end

        @(negedge clk);
        start  = 1'b1;
        is_ntt = mode;
        for (int k = 1; k <= 1200; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                check_val({pfx, "_busy_k1"}, 32'(busy), 1);
                check_val({pfx, "_mode_k1"}, 32'(bf_mode), 32'(mode));
                check_val({pfx, "_rd_en_k1"}, 32'(rd_en), 1);
            end
            if (arb && k == 10) begin
                host_req = 1'b1;
                start    = 1'b1;
                is_ntt   = ~mode;
            end
            if (arb && k == 12) begin
                start  = 1'b0;
                is_ntt = mode;
            end
            if (done) begin
                done_k = k;
                break;
            end
            if (!busy) busy_bad++;
            if (host_gnt) gnt_hi++;
            if (bf_in_valid !== prev_rd) vld_bad++;
            prev_rd = rd_en;

            if (rd_en) begin
                s = int'(layer);
                if (rcnt[s] == 0) begin
                    first_rd[s] = k;
                    check_val($sformatf("%s_l%0d_first_a0", pfx, s), 32'(rd_addr0), 0);
                    check_val($sformatf("%s_l%0d_first_a1", pfx, s), 32'(rd_addr1),
                              32'(mode ? fwd_a1[s] : inv_a1[s]));
                    check_val($sformatf("%s_l%0d_first_tw", pfx, s), 32'(tw_addr),
                              32'(mode ? fwd_tw[s] : inv_tw[s]));
                end
                // forward layer 1, i=65: len 64, group 1, offset 1
                if (mode && s == 1 && rcnt[s] == 65) begin
                    check_val("fwd_l1_i65_a0", 32'(rd_addr0), 129);
                    check_val("fwd_l1_i65_a1", 32'(rd_addr1), 193);
                    check_val("fwd_l1_i65_tw", 32'(tw_addr), 3);
                end
                // inverse layer 2, i=13: len 8, group 1, offset 5
                if (!mode && s == 2 && rcnt[s] == 13) begin
                    check_val("inv_l2_i13_a0", 32'(rd_addr0), 21);
                    check_val("inv_l2_i13_a1", 32'(rd_addr1), 29);
                    check_val("inv_l2_i13_tw", 32'(tw_addr), 30);
                end
                rcnt[s]++;
                last_rd[s] = k;
                cov_rd[s][rd_addr0]++;
                cov_rd[s][rd_addr1]++;
                exp_q.push_back({layer, 14'(k), rd_addr0, rd_addr1});
                n_rd++;
            end else if (rd_addr0 != 0 || rd_addr1 != 0 || tw_addr != 0) begin
                idle_bad++;
            end

            if (wr_en) begin
                n_wr++;
                if (exp_q.size() == 0) begin
                    wb_bad++;
                end else begin
                    e = exp_q.pop_front();
                    if (e[29:16] != 14'(k - (LAT + 1)) || e[15:8] != wr_addr0 || e[7:0] != wr_addr1)
                        wb_bad++;
                    last_wr[e[32:30]] = k;
                    cov_wr[e[32:30]][wr_addr0]++;
                    cov_wr[e[32:30]][wr_addr1]++;
                end
            end else if (wr_addr0 != 0 || wr_addr1 != 0) begin
                idle_bad++;
            end
        end

        for (int l = 0; l < 7; l++)
            for (int a = 0; a < 256; a++)
                if (cov_rd[l][a] != 1 || cov_wr[l][a] != 1) cov_bad++;

        check_val({pfx, "_done_latency"}, 32'(done_k), 932);
        check_val({pfx, "_rd_count"}, 32'(n_rd), 896);
        check_val({pfx, "_wr_count"}, 32'(n_wr), 896);
        check_val({pfx, "_wb_pair_timing"}, 32'(wb_bad), 0);
        check_val({pfx, "_wb_left"}, 32'(exp_q.size()), 0);
        check_val({pfx, "_addr_coverage"}, 32'(cov_bad), 0);
        check_val({pfx, "_idle_addr_zero"}, 32'(idle_bad), 0);
        check_val({pfx, "_bf_in_valid"}, 32'(vld_bad), 0);
        check_val({pfx, "_busy_run"}, 32'(busy_bad), 0);
        check_val({pfx, "_gnt_while_busy"}, 32'(gnt_hi), 0);
        check_val({pfx, "_mode_held"}, 32'(bf_mode), 32'(mode));
        for (int l = 0; l < 6; l++) begin
            check_val($sformatf("%s_l%0d_raw_gap", pfx, l), 32'(first_rd[l+1] - last_wr[l]), 1);
            check_val($sformatf("%s_l%0d_idle_rd", pfx, l), 32'(first_rd[l+1] - last_rd[l] - 1), 5);
        end

        // One cycle after done: back in IDLE, host owns the RAM if it asked.
        @(negedge clk);
        check_val({pfx, "_done_pulse"}, 32'(done), 0);
        check_val({pfx, "_busy_after"}, 32'(busy), 0);
        check_val({pfx, "_gnt_after"}, 32'(host_gnt), arb ? 1 : 0);
        host_req = 1'b0;
    endtask

    // ---------------- arbitration in IDLE ----------------
    task automatic idle_arbitration();
        @(negedge clk);
        host_req = 1'b1;
        start    = 1'b1;
        is_ntt   = 1'b1;
        @(negedge clk);
        check_val("arb_busy", 32'(busy), 0);
        check_val("arb_gnt", 32'(host_gnt), 1);
        check_val("arb_rd_en", 32'(rd_en), 0);
        @(negedge clk);
        check_val("arb_busy_hold", 32'(busy), 0);
        host_req = 1'b0;
        start    = 1'b0;
        @(negedge clk);
        check_val("arb_gnt_drop", 32'(host_gnt), 0);
        check_val("arb_state_idle", 32'(dbg_state_o), 0);
    endtask

    // ---------------- reset in mid-transform ----------------
    task automatic reset_midrun();
        int wr_seen = 0;
        int busy_seen = 0;
        @(negedge clk);
        start  = 1'b1;
        is_ntt = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 1000 && layer != 3'd3; k++) @(negedge clk);
        check_val("rst_reach_l3", 32'(layer), 3);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (wr_en) wr_seen++;
            if (busy) busy_seen++;
        end
        check_val("rst_no_wr_after", 32'(wr_seen), 0);
        check_val("rst_no_busy_after", 32'(busy_seen), 0);
        start  = 1'b1;
        is_ntt = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("rst_restart_rd_en", 32'(rd_en), 1);
        check_val("rst_restart_a0", 32'(rd_addr0), 0);
        check_val("rst_restart_a1", 32'(rd_addr1), 128);
        check_val("rst_restart_tw", 32'(tw_addr), 1);
        check_val("rst_restart_layer", 32'(layer), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        is_ntt   = 1'b0;
        host_req = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_transform(1'b1, 1'b0);
        run_transform(1'b0, 1'b0);
        idle_arbitration();
        run_transform(1'b1, 1'b1);
        reset_midrun();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
